// File: rtl/mem_timing_wrp.sv
// mem_timing_wrp: single-bank DRAM timing emulator with a behavioural store behind a DDR-style DQ port.
// halt freezes the FSM, timing counters, read pipeline and outputs so host stalls stay invisible.
module mem_timing_wrp #(
  parameter int WIDTH = 4,
  parameter int ROWS  = 131072,
  parameter int COLS  = 1024,
  parameter int TRCD  = 4,
  parameter int TRP   = 4,
  parameter int TCL   = 3,
  parameter int TRFC  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     halt,
  input  logic                     ACT,
  input  logic                     BST,
  input  logic                     CFG,
  input  logic                     CKEH,
  input  logic                     CKEL,
  input  logic                     DPD,
  input  logic                     DPDX,
  input  logic                     MRR,
  input  logic                     MRW,
  input  logic                     PD,
  input  logic                     PDX,
  input  logic                     PR,
  input  logic                     PRA,
  input  logic                     RD,
  input  logic                     RDA,
  input  logic                     REF,
  input  logic                     SRF,
  input  logic                     WR,
  input  logic                     WRA,
  inout  wire  [WIDTH-1:0]         dq,
  inout  wire                      dqs_c,
  inout  wire                      dqs_t,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  column
);
  localparam int AW = $clog2(ROWS) + $clog2(COLS);
  typedef enum logic [3:0] {
    IDLE, ACTIVATING, ACTIVE, WRITING, READING,
    PRECHARGING, REFRESHING, POWERDOWN, SELFREFRESH, DEEPPD
  } state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] addr;
  logic [AW-1:0] pa_q [TCL];
  logic [TCL-1:0] pv_q;
  logic [WIDTH-1:0] do_q;
  logic oe_q, pr, wr, rd, open, we, re;
  logic unused_cmds;
  assign unused_cmds = ^{BST, CFG, CKEL, MRR, MRW};
  assign addr = {row, column};
  assign pr   = PR | PRA;
  assign wr   = WR | WRA;
  assign rd   = RD | RDA;
  assign open = state_q inside {ACTIVE, WRITING, READING};
  assign we   = !halt && open && wr && !pr;
  assign re   = !halt && open && rd && !wr && !pr;
  assign dq    = oe_q ? do_q : {WIDTH{1'bz}};
  assign dqs_t = oe_q ? 1'b1 : 1'bz;
  assign dqs_c = oe_q ? 1'b0 : 1'bz;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ACT) begin
          state_d = ACTIVATING;
          cnt_d   = 8'(TRCD);
        end else if (REF) begin
          state_d = REFRESHING;
          cnt_d   = 8'(TRFC);
        end else if (PD) state_d = POWERDOWN;
        else if (SRF) state_d = SELFREFRESH;
        else if (DPD) state_d = DEEPPD;
      end
      ACTIVATING, PRECHARGING, REFRESHING: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = (state_q == ACTIVATING) ? ACTIVE : IDLE;
        end
      end
      ACTIVE, WRITING, READING: begin
        // auto-precharge variants perform their access on this edge, then close the bank
        state_d = pr ? PRECHARGING
                : wr ? (WRA ? PRECHARGING : WRITING)
                : rd ? (RDA ? PRECHARGING : READING)
                : ACTIVE;
        cnt_d   = (state_d == PRECHARGING) ? 8'(TRP) : cnt_q;
      end
      POWERDOWN:   state_d = PDX  ? IDLE : state_q;
      SELFREFRESH: state_d = CKEH ? IDLE : state_q;
      DEEPPD:      state_d = DPDX ? IDLE : state_q;
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pv_q    <= '0;
      oe_q    <= 1'b0;
      do_q    <= '0;
    end else if (!halt) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q[0] <= re;
      for (int i = 1; i < TCL; i++) pv_q[i] <= pv_q[i-1];
      oe_q    <= pv_q[TCL-1];
      do_q    <= mem[pa_q[TCL-1]];
    end
  end
  always_ff @(posedge clk) begin
    if (!halt) begin
      pa_q[0] <= addr;
      for (int i = 1; i < TCL; i++) pa_q[i] <= pa_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= dq;
  end
endmodule

// File: tb/tb_mem_timing_wrp.sv
// tb_mem_timing_wrp: directed checks of bank timing, write/read data path, halt and reset behaviour.
module tb_mem_timing_wrp;
  logic clk = 0, rst = 1, halt = 0;
  logic ACT = 0, BST = 0, CFG = 0, CKEH = 0, CKEL = 0, DPD = 0, DPDX = 0, MRR = 0, MRW = 0, PD = 0;
  logic PDX = 0, PR = 0, PRA = 0, RD = 0, RDA = 0, REF = 0, SRF = 0, WR = 0, WRA = 0;
  logic [1:0] row = 0;
  logic [2:0] column = 0;
  logic [3:0] dq_drv = 0;
  logic dq_en = 0;
  wire [3:0] dq;
  wire dqs_c, dqs_t;
  int n_chk = 0, n_fail = 0;
  localparam logic [3:0] S_IDLE = 0, S_ACTG = 1, S_ACTV = 2, S_WR = 3, S_PRE = 5, S_REF = 6;
  logic [1:0] rv [6] = '{0, 1, 0, 1, 0, 1};
  logic [2:0] cv [6] = '{1, 4, 7, 0, 3, 6};
  logic [3:0] dv [6] = '{2, 5, 8, 1, 4, 7};
  int hv [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  int ri [12] = '{0, 1, 2, 3, 4, 5, -1, 5, -1, -1, -1, -1};
  int ei [12] = '{-1, -1, -1, 0, 1, 1, 1, 2, 3, 4, 5, -1};
  assign dq = dq_en ? dq_drv : 4'bz;
  always #5 clk = ~clk;
  mem_timing_wrp #(.WIDTH(4), .ROWS(4), .COLS(8), .TRCD(4), .TRP(4), .TCL(3), .TRFC(16)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD), .DPDX(DPDX),
    .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA),
    .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA),
    .dq(dq), .dqs_c(dqs_c), .dqs_t(dqs_t), .row(row), .column(column)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_z(input string tag);
    chk({tag, "_dq"}, dq, 4'bz);
    chk({tag, "_dqs_t"}, {3'b0, dqs_t}, {3'b0, 1'bz});
    chk({tag, "_dqs_c"}, {3'b0, dqs_c}, {3'b0, 1'bz});
  endtask
  task automatic chk_d(input string tag, input logic [3:0] d);
    chk({tag, "_dq"}, dq, d);
    chk({tag, "_dqs_t"}, {3'b0, dqs_t}, 4'b0001);
    chk({tag, "_dqs_c"}, {3'b0, dqs_c}, 4'b0000);
  endtask
  task automatic st(input string tag, input logic [3:0] s);
    chk(tag, 4'(dut.state_q), s);
  endtask
  task automatic set_addr(input int i);
    row = rv[i];
    column = cv[i];
  endtask
  initial begin
    tick; tick;
    rst = 0;
    tick;
    chk_z("reset");
    st("reset_state", S_IDLE);
    ACT = 1; tick; ACT = 0;
    st("act_entry", S_ACTG);
    repeat (3) tick;
    st("trcd_m1", S_ACTG);
    tick;
    st("trcd", S_ACTV);
    PR = 1; tick; PR = 0;
    st("pr_entry", S_PRE);
    repeat (3) tick;
    st("trp_m1", S_PRE);
    tick;
    st("trp", S_IDLE);
    ACT = 1; tick; ACT = 0;
    tick;
    halt = 1; repeat (3) tick; halt = 0;
    repeat (2) tick;
    st("halt_trcd_m1", S_ACTG);
    tick;
    st("halt_trcd", S_ACTV);
    dq_en = 1; WR = 1;
    for (int i = 0; i < 6; i++) begin
      set_addr(i);
      dq_drv = dv[i];
      tick;
    end
    WR = 0; dq_en = 0;
    st("writing", S_WR);
    for (int k = 0; k <= 10; k++) begin
      RD = (k < 6);
      PR = (k == 6);
      if (k < 6) set_addr(k);
      tick;
      if (k >= 3 && k <= 8) chk_d($sformatf("burst%0d", k), dv[k-3]);
      else chk_z($sformatf("burst%0d", k));
      if (k == 6 || k == 9) st($sformatf("pr_state%0d", k), S_PRE);
      if (k == 10) st("pr_idle", S_IDLE);
    end
    RD = 0; PR = 0;
    ACT = 1; tick; ACT = 0;
    repeat (4) tick;
    st("reopen", S_ACTV);
    for (int s = 0; s < 12; s++) begin
      halt = hv[s][0];
      RD = (ri[s] >= 0);
      if (ri[s] >= 0) set_addr(ri[s]);
      tick;
      if (ei[s] < 0) chk_z($sformatf("halt%0d", s));
      else chk_d($sformatf("halt%0d", s), dv[ei[s]]);
    end
    halt = 0; RD = 0;
    PR = 1; tick; PR = 0;
    repeat (4) tick;
    st("halt_pr_idle", S_IDLE);
    RD = 1; set_addr(0); tick; RD = 0;
    st("idle_rd_state", S_IDLE);
    repeat (4) tick;
    chk_z("idle_rd");
    REF = 1; tick; REF = 0;
    st("ref_entry", S_REF);
    RD = 1;
    repeat (14) tick;
    RD = 0;
    tick;
    st("trfc_m1", S_REF);
    tick;
    st("trfc", S_IDLE);
    repeat (3) tick;
    chk_z("ref_rd");
    ACT = 1; tick; ACT = 0;
    repeat (4) tick;
    RD = 1; set_addr(0); tick;
    set_addr(1); tick;
    RD = 0;
    tick; tick;
    chk_d("pre_rst", dv[0]);
    rst = 1;
    #1;
    chk_z("rst_async");
    st("rst_state", S_IDLE);
    tick;
    rst = 0;
    tick; tick;
    chk_z("rst_abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
